// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt capture, masking, priority and claim/complete servicing
// Optional feature macro: IRQ_LEVEL_EN selects level-sensitive capture (edge capture when undefined).
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   irq_src_i    raw peripheral interrupt lines {epu, sctrl, dma1, dma0}
//   req_i        register access request (single cycle)
//   we_i         1 = write, 0 = read
//   addr_i       byte address, word select in [3:2]
//   wdata_i      write data
//   rdata_o      registered read data, valid with ack_o, held otherwise
//   ack_o        completion, the cycle after req_i
//   interrupt_o  one-hot highest-priority eligible source while idle
//   irq_valid_o  OR of interrupt_o
module irq_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_src_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic [N_SRC-1:0]  interrupt_o,
  output logic              irq_valid_o
);

  localparam logic ST_IDLE       = 1'b0;
  localparam logic ST_IN_SERVICE = 1'b1;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_CLAIM   = 2'd2;
  localparam logic [1:0] REG_RAW     = 2'd3;

  logic              state;
  logic [N_SRC-1:0]  enable;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  pending_next;
  logic [ID_W-1:0]   cur_id;

  logic [N_SRC-1:0]  eligible;
  logic              any_eligible;
  logic [ID_W-1:0]   win_id;
  logic [N_SRC-1:0]  win_onehot;

  logic [1:0]        reg_sel;
  logic              rd_claim;
  logic              claim_ok;
  logic              wr_enable;
  logic              wr_complete;
  logic [31:0]       rdata_next;

  // Byte-lane and upper data bits are never decoded.
  logic              unused_bits;
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:N_SRC]};

  assign reg_sel      = addr_i[3:2];
  assign eligible     = pending & enable;
  assign any_eligible = |eligible;

  // Later iterations overwrite earlier ones, so the highest index wins.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  assign win_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << win_id;

  assign rd_claim    = req_i && !we_i && (reg_sel == REG_CLAIM);
  assign claim_ok    = rd_claim && (state == ST_IDLE) && any_eligible;
  assign wr_enable   = req_i && we_i && (reg_sel == REG_ENABLE);
  assign wr_complete = req_i && we_i && (reg_sel == REG_CLAIM);

`ifdef IRQ_LEVEL_EN
  // Pending simply mirrors the lines one cycle late; W1C and claim cannot clear it.
  assign pending_next = irq_src_i;
`else
  logic [N_SRC-1:0]  src_q;
  logic [N_SRC-1:0]  edge_det;
  logic [N_SRC-1:0]  clr;
  logic              wr_pending;

  assign wr_pending = req_i && we_i && (reg_sel == REG_PENDING);
  assign edge_det   = irq_src_i & ~src_q;

  always_comb begin
    clr = '0;
    if (wr_pending) clr = wdata_i[N_SRC-1:0];
    if (claim_ok)   clr = clr | win_onehot;
  end

  // OR-ing the edge in last lets a fresh edge survive a same-cycle clear.
  assign pending_next = (pending & ~clr) | edge_det;

  // Reset to 0 so a line already high at reset release counts as an edge.
  always_ff @(posedge clk) begin
    if (!rst) src_q <= '0;
    else      src_q <= irq_src_i;
  end
`endif

  always_comb begin
    rdata_next = '0;
    case (reg_sel)
      REG_ENABLE:  rdata_next = 32'(enable);
      REG_PENDING: rdata_next = 32'(pending);
      REG_CLAIM:   rdata_next = claim_ok ? 32'(win_id) : 32'hFFFF_FFFF;
      REG_RAW:     rdata_next = 32'(irq_src_i);
      default:     rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      enable  <= '0;
      pending <= '0;
      cur_id  <= '0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      ack_o <= req_i;
      if (req_i && !we_i) rdata_o <= rdata_next;
      if (wr_enable) enable <= wdata_i[N_SRC-1:0];
      pending <= pending_next;
      case (state)
        ST_IDLE: begin
          if (claim_ok) begin
            cur_id <= win_id;
            state  <= ST_IN_SERVICE;
          end
        end
        ST_IN_SERVICE: begin
          if (wr_complete && (wdata_i[ID_W-1:0] == cur_id)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Nothing is offered to the CPU while a claimed source is being serviced.
  assign interrupt_o = ((state == ST_IDLE) && any_eligible) ? win_onehot : '0;
  assign irq_valid_o = |interrupt_o;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - randomized and directed bench for irq_ctrl against a behavioural model
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq_src_i = '0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic [3:0]  interrupt_o;
  logic        irq_valid_o;

  irq_ctrl #(.N_SRC(4), .ID_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_src_i   (irq_src_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .ack_o       (ack_o),
    .interrupt_o (interrupt_o),
    .irq_valid_o (irq_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one flag per source, an in-service flag and the claimed id.
  bit          m_pend[4];
  bit          m_en[4];
  bit          m_prev[4];
  bit          m_svc;
  int          m_cur;
  bit          m_ack;
  logic [31:0] m_rdata;

  function automatic int winner();
    int w = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i] && m_en[i]) w = i;
    return w;
  endfunction

  function automatic logic [31:0] as_word(input bit b[4]);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) if (b[i]) v = v + (32'd1 << i);
    return v;
  endfunction

  function automatic logic [31:0] exp_intr();
    int w = winner();
    if (!m_svc && w >= 0) return 32'd1 << w;
    return 0;
  endfunction

  task automatic model_edge(input bit r, input logic [3:0] src, input bit rq, input bit wr,
                            input logic [3:0] a, input logic [31:0] d);
    int  w = winner();
    bit  clr[4];
    bit  edg[4];
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0; m_en[i] = 0; m_prev[i] = 0;
      end
      m_svc = 0; m_cur = 0; m_ack = 0; m_rdata = 0;
      return;
    end
    m_ack = rq;
    for (int i = 0; i < 4; i++) begin
      clr[i] = 0;
      edg[i] = src[i] && !m_prev[i];
    end
    if (rq && !wr) begin
      case (a[3:2])
        2'd0: m_rdata = as_word(m_en);
        2'd1: m_rdata = as_word(m_pend);
        2'd2: begin
          if (!m_svc && w >= 0) begin
            m_rdata = w;
            clr[w]  = 1;
            m_svc   = 1;
            m_cur   = w;
          end else begin
            m_rdata = 32'hFFFF_FFFF;
          end
        end
        default: m_rdata = {28'd0, src};
      endcase
    end
    if (rq && wr) begin
      case (a[3:2])
        2'd0: for (int i = 0; i < 4; i++) m_en[i] = d[i];
        2'd1: for (int i = 0; i < 4; i++) if (d[i]) clr[i] = 1;
        2'd2: if (m_svc && int'(d[1:0]) == m_cur) m_svc = 0;
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
`ifdef IRQ_LEVEL_EN
      m_pend[i] = src[i];
`else
      m_pend[i] = (m_pend[i] && !clr[i]) || edg[i];
`endif
      m_prev[i] = src[i];
    end
  endtask

  task automatic step(input bit r, input logic [3:0] src, input bit rq, input bit wr,
                      input logic [3:0] a, input logic [31:0] d);
    rst = r; irq_src_i = src; req_i = rq; we_i = wr; addr_i = a; wdata_i = d;
    @(posedge clk);
    model_edge(r, src, rq, wr, a, d);
    #1;
    check("ack", {31'd0, ack_o}, {31'd0, m_ack});
    check("rdata", rdata_o, m_rdata);
    check("interrupt", {28'd0, interrupt_o}, exp_intr());
    check("irq_valid", {31'd0, irq_valid_o}, {31'd0, exp_intr() != 0});
  endtask

  task automatic idle(input logic [3:0] src);
    step(1, src, 0, 0, 4'h0, 0);
  endtask

  logic [3:0]  r_src;
  logic [31:0] r_data;

  initial begin
    step(0, 4'h0, 0, 0, 4'h0, 0);
    step(0, 4'h0, 0, 0, 4'h0, 0);
    check("rst_interrupt", {28'd0, interrupt_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);

`ifndef IRQ_LEVEL_EN
    // Single pulse on sctrl, then claim it.
    step(1, 4'h0, 1, 1, 4'h0, 32'hF);
    idle(4'b0100);
    check("pulse_intr", {28'd0, interrupt_o}, 32'h4);
    step(1, 4'h0, 1, 0, 4'h8, 0);
    check("claim2_ack", {31'd0, ack_o}, 32'd1);
    check("claim2_id", rdata_o, 32'd2);
    step(1, 4'h0, 1, 1, 4'h8, 32'd2);

    // Two pending: highest wins, second claim refused until complete.
    idle(4'b1001);
    step(1, 4'h0, 1, 0, 4'h8, 0);
    check("claim3_id", rdata_o, 32'd3);
    step(1, 4'h0, 1, 0, 4'h8, 0);
    check("claim_busy", rdata_o, 32'hFFFF_FFFF);
    step(1, 4'h0, 1, 1, 4'h8, 32'd3);
    check("after_complete3", {28'd0, interrupt_o}, 32'h1);
    step(1, 4'h0, 1, 0, 4'h8, 0);
    check("claim0_id", rdata_o, 32'd0);
    step(1, 4'h0, 1, 1, 4'h8, 32'd0);

    // Disabled source still latches pending.
    step(1, 4'h0, 1, 1, 4'h0, 32'h0);
    idle(4'b0010);
    check("masked_intr", {28'd0, interrupt_o}, 32'd0);
    step(1, 4'h0, 1, 0, 4'h4, 0);
    check("masked_pending", rdata_o, 32'h2);
    step(1, 4'h0, 1, 1, 4'h0, 32'h2);
    check("late_enable", {28'd0, interrupt_o}, 32'h2);
    step(1, 4'h0, 1, 1, 4'h4, 32'h2);

    // W1C and a new edge on the same bit: set wins.
    step(1, 4'b0001, 1, 1, 4'h4, 32'h1);
    step(1, 4'h0, 1, 0, 4'h4, 0);
    check("w1c_vs_edge", rdata_o, 32'h1);
    step(1, 4'h0, 1, 1, 4'h4, 32'h1);

    // Mismatched complete ignored, then reset mid-service.
    step(1, 4'h0, 1, 1, 4'h0, 32'hF);
    idle(4'b0100);
    step(1, 4'h0, 1, 0, 4'h8, 0);
    check("claim_cur2", rdata_o, 32'd2);
    idle(4'b0001);
    step(1, 4'h0, 1, 1, 4'h8, 32'd1);
    check("bad_complete", {28'd0, interrupt_o}, 32'd0);
    step(1, 4'h0, 1, 1, 4'h8, 32'd2);
    check("good_complete", {28'd0, interrupt_o}, 32'h1);
    step(1, 4'h0, 1, 0, 4'h8, 0);
    step(0, 4'h0, 0, 0, 4'h0, 0);
    check("midrst_intr", {28'd0, interrupt_o}, 32'd0);
    check("midrst_ack", {31'd0, ack_o}, 32'd0);
    step(1, 4'h0, 1, 0, 4'h0, 0);
    check("midrst_enable", rdata_o, 32'd0);
    step(1, 4'h0, 1, 0, 4'h8, 0);
    check("midrst_claim", rdata_o, 32'hFFFF_FFFF);
`else
    // Held line stays pending through claim and W1C.
    step(1, 4'b0100, 1, 1, 4'h0, 32'hF);
    idle(4'b0100);
    step(1, 4'b0100, 1, 0, 4'h8, 0);
    check("lvl_claim", rdata_o, 32'd2);
    step(1, 4'b0100, 1, 0, 4'h4, 0);
    check("lvl_pend_after_claim", rdata_o, 32'h4);
    step(1, 4'b0100, 1, 1, 4'h4, 32'h4);
    step(1, 4'b0100, 1, 0, 4'h4, 0);
    check("lvl_w1c_noop", rdata_o, 32'h4);
    idle(4'h0);
    step(1, 4'h0, 1, 1, 4'h8, 32'd2);
    check("lvl_complete", {28'd0, interrupt_o}, 32'd0);
`endif

    // Random traffic against the model.
    r_src = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) r_src[i] = ~r_src[i];
      r_data = $urandom;
      if ($urandom_range(299) == 0)
        step(0, r_src, 0, 0, 4'h0, 0);
      else
        step(1, r_src, $urandom_range(1), $urandom_range(1), 4'($urandom_range(15)), r_data);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt aggregation stage between the peripheral interrupt lines (DMA channel 0/1, sensor controller, EPU) and the CPU wrapper's `interrupt_i` input. It captures each source into a pending bit, applies a software-programmed enable mask and resolves priority. It enforces one-at-a-time claim/complete servicing through a small FSM. The CPU programs it through a simple single-cycle register port driven by a thin bus bridge.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources; equals `INT_BITS`. Bit order is {epu, sctrl, dma[1], dma[0]}.
- `ID_W`, 2: width of a source id; equals clog2(N_SRC).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `irq_src_i`  in  N_SRC  raw peripheral interrupt lines.
- `req_i`  in  1  register access request.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  4  byte address; bits [1:0] ignored.
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  read data; valid when `ack_o` = 1.
- `ack_o`  out  1  access completion.
- `interrupt_o`  out  N_SRC  one-hot line to the CPU wrapper. Set to the highest-priority enabled pending source while IDLE, otherwise 0.
- `irq_valid_o`  out  1  equals the OR of `interrupt_o`.

## Operation
- Registers:
  - 0x0 ENABLE: RW, bits [N_SRC-1:0].
  - 0x4 PENDING: read returns the pending bits. A write clears every bit written as 1 (W1C).
  - 0x8 CLAIM: a read claims the winning source. A write is COMPLETE for the id in `wdata_i`.
  - 0xC RAW: RO, current `irq_src_i`.
  - Unmapped addresses read 0; writes to them are ignored.
- Capture (edge mode):
  - `src_q` <= `irq_src_i` every cycle.
  - `edge` = `irq_src_i` & ~`src_q`.
  - `pending` <= (`pending` & ~clr) | `edge`.
- Disabled sources still latch pending. Enabling one later raises the interrupt on the next cycle.
- Priority: the highest index wins (EPU > SCTRL > DMA1 > DMA0).
- FSM states: IDLE, IN_SERVICE.
  - IDLE, CLAIM read with an enabled pending source: `rdata` = winning id, that pending bit is cleared, the id is stored in `cur_id`, go to IN_SERVICE.
  - IDLE, CLAIM read with no eligible source: `rdata` = 0xFFFF_FFFF, stay in IDLE.
  - IN_SERVICE, CLAIM read: `rdata` = 0xFFFF_FFFF, no side effect.
  - IN_SERVICE, COMPLETE write with `wdata_i[ID_W-1:0]` == `cur_id`: go to IDLE.
  - COMPLETE with a mismatched id, or while in IDLE: ignored.
- Simultaneous events:
  - A new edge and a W1C on the same bit in the same cycle: set wins.
  - A new edge on the source being claimed in the claim cycle: the bit stays pending.

## Timing
- Reset (rst = 0 at a clock edge) clears the following, mid-transaction included:
  - `pending`, ENABLE, `src_q`, `cur_id` to 0.
  - State to IDLE.
  - `ack_o`, `rdata_o`, `interrupt_o`, `irq_valid_o` to 0.
- A source already high when reset is released is seen as a rising edge in the first cycle.
- Source to output latency: `irq_src_i` rises before edge k; `pending` and `interrupt_o` are high after edge k (1 cycle). `interrupt_o` is decoded combinationally from registered `pending`, ENABLE and state.
- Register port:
  - `req_i` sampled at edge k gives `ack_o` = 1 for exactly the cycle after k, with registered `rdata_o`.
  - Write and claim side effects take effect at edge k.
  - Back-to-back requests are allowed every cycle; each produces one ack.
  - `rdata_o` holds its last value when `ack_o` = 0.
- After a claim, `interrupt_o` drops in the cycle following edge k.
- After COMPLETE, the next eligible interrupt appears in the cycle following edge k.

## Configuration
- `IRQ_LEVEL_EN` defined: level-sensitive mode.
  - `pending` = `irq_src_i` registered each cycle; `src_q` and edge logic are removed.
  - PENDING W1C has no effect.
  - A claim does not clear pending; the peripheral must deassert its line before COMPLETE.
- `IRQ_LEVEL_EN` undefined: edge capture as described above (default).

## Test plan
- Reset with `irq_src_i` = 0: ENABLE = 0xF; pulse `irq_src_i` = 4'b0100 for 1 cycle → `interrupt_o` = 4'b0100 one cycle later; CLAIM read returns 2, with `ack_o` one cycle after `req_i`.
- Pending 4'b1001, all enabled → CLAIM returns 3. A second CLAIM returns 0xFFFF_FFFF. COMPLETE(3) → `interrupt_o` = 4'b0001 in the next cycle; CLAIM returns 0.
- ENABLE = 0, pulse source 1 → `interrupt_o` = 0 and PENDING reads 0x2. Write ENABLE = 0x2 → `interrupt_o` = 4'b0010 in the next cycle.
- W1C PENDING = 0x1 in the same cycle as a new edge on source 0 → PENDING reads 0x1.
- In IN_SERVICE with `cur_id` = 2: COMPLETE(1) is ignored (`interrupt_o` stays 0); COMPLETE(2) returns the FSM to IDLE.
- rst = 0 for one cycle mid-service → all outputs 0, ENABLE reads 0, CLAIM returns 0xFFFF_FFFF. With `IRQ_LEVEL_EN`: a held line stays pending after claim, and PENDING W1C has no effect.
